tl_phase_sched: RTL and testbench

Timed phase scheduler for a two-street intersection. Sequences the green/yellow/red phases of street A and street B from the traffic sensors Ta/Tb. Enforces minimum green, maximum green, fixed yellow and all-red clearance times, and an optional pedestrian all-red walk phase. It is the timed, arbitrating successor to the untimed two-sensor light controller and drives the same La/Lb lamp buses.

---
 rtl/tl_phase_sched.sv | 142 ++++++++++++++
 tb/tb_tl_phase_sched.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tl_phase_sched.sv
// Timed two-street phase scheduler with min/max green, fixed yellow and all-red clearance.
// Optional pedestrian all-red walk phase is built when TL_PED_EN is defined.
module tl_phase_sched #(
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 12,
    parameter int YELLOW    = 3,
    parameter int ALLRED    = 1,
    parameter int PED_TIME  = 6,
    parameter int CW        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Ta,
    input  logic       Tb,
    input  logic       ped_req,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        ST_AG  = 3'd0,
        ST_AY  = 3'd1,
        ST_AR  = 3'd2,
        ST_BG  = 3'd3,
        ST_BY  = 3'd4,
        ST_BR  = 3'd5,
        ST_PED = 3'd6
    } state_t;

    localparam logic [CW-1:0] MIN_M1  = CW'(MIN_GREEN - 1);
    localparam logic [CW-1:0] MAX_M1  = CW'(MAX_GREEN - 1);
    localparam logic [CW-1:0] YEL_M1  = CW'(YELLOW - 1);
    localparam logic [CW-1:0] AR_M1   = CW'(ALLRED - 1);
    localparam logic [CW-1:0] PED_M1  = CW'(PED_TIME - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ped_pend;
    logic          min_hit, max_hit, req_a, req_b;

`ifdef TL_PED_EN
    logic ped_pend_q, ped_pend_d;
    logic side_q, side_d;   // 0: street A held green before PED, 1: street B
    logic enter_ped;

    assign ped_pend  = ped_pend_q;
    assign enter_ped = (state_d == ST_PED) && (state_q != ST_PED);

    always_comb begin
        ped_pend_d = (ped_pend_q & ~enter_ped) | ped_req;
        side_d     = side_q;
        if (enter_ped) begin
            side_d = (state_q == ST_BY);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ped_pend_q <= 1'b0;
            side_q     <= 1'b0;
        end else begin
            ped_pend_q <= ped_pend_d;
            side_q     <= side_d;
        end
    end
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
    assign ped_pend       = 1'b0;
`endif

    assign min_hit = (cnt_q >= MIN_M1);
    assign max_hit = (cnt_q >= MAX_M1);
    assign req_a   = Ta & (~Tb | max_hit);
    assign req_b   = Tb & (~Ta | max_hit);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_AG: if (min_hit && (req_b || ped_pend)) state_d = ST_BY == ST_BY ? ST_AY : ST_AY;
            ST_AY: if (cnt_q == YEL_M1) state_d = ped_pend ? ST_PED : ST_AR;
            ST_AR: if (cnt_q == AR_M1) state_d = ST_BG;
            ST_BG: if (min_hit && (req_a || ped_pend)) state_d = ST_BY;
            ST_BY: if (cnt_q == YEL_M1) state_d = ped_pend ? ST_PED : ST_BR;
            ST_BR: if (cnt_q == AR_M1) state_d = ST_AG;
`ifdef TL_PED_EN
            ST_PED: if (cnt_q == PED_M1) state_d = side_q ? ST_AG : ST_BG;
`else
            ST_PED: state_d = ST_AG;
`endif
            default: state_d = ST_AG;
        endcase
    end

    // Dwell counter restarts on every state change and saturates while a green is held.
    always_comb begin
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_AG;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        La    = 2'b10;
        Lb    = 2'b10;
        phase = state_q;
        case (state_q)
            ST_AG:   La = 2'b00;
            ST_AY:   La = 2'b01;
            ST_BG:   Lb = 2'b00;
            ST_BY:   Lb = 2'b01;
            default: ;
        endcase
`ifdef TL_PED_EN
        walk = (state_q == ST_PED);
`else
        walk = 1'b0;
`endif
    end

`ifndef TL_PED_EN
    logic [CW-1:0] unused_ped_m1;
    assign unused_ped_m1 = PED_M1;
`endif

endmodule

// File: tb/tb_tl_phase_sched.sv
// Segment-table bench for tl_phase_sched: each record holds inputs for N cycles and the phase expected in them.
module tb_tl_phase_sched;

    logic       clk;
    logic       reset;
    logic       Ta;
    logic       Tb;
    logic       ped_req;
    logic [1:0] La;
    logic [1:0] Lb;
    logic       walk;
    logic [2:0] phase;

    int tests_run = 0;
    int tests_failed = 0;

    tl_phase_sched dut (
        .clk     (clk),
        .reset   (reset),
        .Ta      (Ta),
        .Tb      (Tb),
        .ped_req (ped_req),
        .La      (La),
        .Lb      (Lb),
        .walk    (walk),
        .phase   (phase)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit rst;
        bit ta;
        bit tb;
        bit pd;
        int len;
        int ph;
        bit chk;
    } seg_t;

    seg_t segs[$];

    task automatic add(input bit rst, input bit ta, input bit tb, input bit pd,
                       input int len, input int ph, input bit chk);
        seg_t s;
        s.rst = rst; s.ta = ta; s.tb = tb; s.pd = pd;
        s.len = len; s.ph = ph; s.chk = chk;
        segs.push_back(s);
    endtask

    task automatic add_reset();
        add(1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0);
    endtask

    // Lamp/walk values each phase code must show.
    function automatic logic [4:0] lamps_of(input int ph);
        case (ph)
            0:       return {2'b00, 2'b10, 1'b0};
            1:       return {2'b01, 2'b10, 1'b0};
            3:       return {2'b10, 2'b00, 1'b0};
            4:       return {2'b10, 2'b01, 1'b0};
            6:       return {2'b10, 2'b10, 1'b1};
            default: return {2'b10, 2'b10, 1'b0};
        endcase
    endfunction

    initial begin
        reset = 1'b1; Ta = 1'b0; Tb = 1'b0; ped_req = 1'b0;

        // A steady, B idle: A keeps green.
        add_reset();
        add(0, 1, 0, 0, 30, 0, 1);

        // B requests from cycle 0, then traffic swaps to A once B is green.
        add_reset();
        add(0, 0, 1, 0, 4, 0, 1);
        add(0, 0, 1, 0, 3, 1, 1);
        add(0, 0, 1, 0, 1, 2, 1);
        add(0, 1, 0, 0, 4, 3, 1);
        add(0, 1, 0, 0, 3, 4, 1);
        add(0, 1, 0, 0, 1, 5, 1);
        add(0, 1, 0, 0, 2, 0, 1);

        // Both streets busy: 32-cycle alternation, twice.
        add_reset();
        for (int k = 0; k < 2; k++) begin
            add(0, 1, 1, 0, 12, 0, 1);
            add(0, 1, 1, 0, 3, 1, 1);
            add(0, 1, 1, 0, 1, 2, 1);
            add(0, 1, 1, 0, 12, 3, 1);
            add(0, 1, 1, 0, 3, 4, 1);
            add(0, 1, 1, 0, 1, 5, 1);
        end
        add(0, 1, 1, 0, 1, 0, 1);

        // Sensors drop during yellow; BG then holds with no traffic past counter saturation.
        add_reset();
        add(0, 0, 1, 0, 4, 0, 1);
        add(0, 0, 0, 0, 3, 1, 1);
        add(0, 0, 0, 0, 1, 2, 1);
        add(0, 0, 0, 0, 20, 3, 1);
        add(0, 1, 0, 0, 1, 3, 1);
        add(0, 1, 0, 0, 3, 4, 1);
        add(0, 1, 0, 0, 1, 5, 1);
        add(0, 1, 0, 0, 1, 0, 1);

        // Pedestrian request, then reset during yellow: no PED afterwards.
        add_reset();
        add(0, 0, 1, 0, 1, 0, 1);
        add(0, 0, 1, 1, 1, 0, 1);
        add(0, 0, 1, 0, 2, 0, 1);
        add(0, 0, 1, 0, 1, 1, 1);
        add(1, 0, 1, 0, 1, 1, 1);
        add(0, 0, 1, 0, 4, 0, 1);
        add(0, 0, 1, 0, 3, 1, 1);
        add(0, 0, 1, 0, 1, 2, 1);
        add(0, 0, 1, 0, 2, 3, 1);

`ifdef TL_PED_EN
        // Walk phase after A's yellow, re-armed during PED, second walk after B's yellow.
        add_reset();
        add(0, 1, 0, 0, 1, 0, 1);
        add(0, 1, 0, 1, 1, 0, 1);
        add(0, 1, 0, 0, 2, 0, 1);
        add(0, 1, 0, 0, 3, 1, 1);
        add(0, 1, 0, 0, 2, 6, 1);
        add(0, 1, 0, 1, 1, 6, 1);
        add(0, 1, 0, 0, 3, 6, 1);
        add(0, 1, 0, 0, 4, 3, 1);
        add(0, 1, 0, 0, 3, 4, 1);
        add(0, 1, 0, 0, 6, 6, 1);
        add(0, 1, 0, 0, 2, 0, 1);
`else
        // Toggling ped_req is ignored: same timing as B-only traffic, walk stays low.
        add_reset();
        for (int k = 0; k < 4; k++) add(0, 0, 1, k % 2 == 0, 1, 0, 1);
        add(0, 0, 1, 1, 1, 1, 1);
        add(0, 0, 1, 0, 1, 1, 1);
        add(0, 0, 1, 1, 1, 1, 1);
        add(0, 0, 1, 1, 1, 2, 1);
        add(0, 0, 1, 0, 3, 3, 1);
`endif

        @(posedge clk);
        #1;
        for (int i = 0; i < segs.size(); i++) begin
            $display("[TB] seg %0d: rst=%0b Ta=%0b Tb=%0b ped=%0b len=%0d phase=%0d",
                     i, segs[i].rst, segs[i].ta, segs[i].tb, segs[i].pd, segs[i].len, segs[i].ph);
            for (int n = 0; n < segs[i].len; n++) begin
                logic [2:0] exp_ph;
                logic [4:0] exp_lamps;
                reset   = segs[i].rst;
                Ta      = segs[i].ta;
                Tb      = segs[i].tb;
                ped_req = segs[i].pd;
                @(negedge clk);
                if (segs[i].chk) begin
                    exp_ph    = 3'(segs[i].ph);
                    exp_lamps = lamps_of(segs[i].ph);
                    tests_run++;
                    if (phase !== exp_ph) begin
                        tests_failed++;
                        $display("[TB] FAIL phase seg %0d cycle %0d: got %0d expected %0d",
                                 i, n, phase, exp_ph);
                    end
                    tests_run++;
                    if ({La, Lb, walk} !== exp_lamps) begin
                        tests_failed++;
                        $display("[TB] FAIL lamps seg %0d cycle %0d: got La=%b Lb=%b walk=%b expected La=%b Lb=%b walk=%b",
                                 i, n, La, Lb, walk, exp_lamps[4:3], exp_lamps[2:1], exp_lamps[0]);
                    end
                end
                @(posedge clk);
                #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
